// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//
// Shares one uart_tx transmitter between REQ_COUNT byte-stream requesters.
// Arbitration is round-robin and packet-atomic. Once a requester is granted, it keeps the
// transmitter until it sends a byte flagged last, or until it holds req_valid low for TIMEOUT
// consecutive cycles while the arbiter is waiting for its next byte. Each byte is sequenced off
// the uart_tx done level: start pulse, wait for done to fall, then wait for done to rise.
//
// Ports
//   clk          system clock
//   rst          synchronous reset, active high
//   req_valid    per requester: a byte is offered on req_data[8r+:8]
//   req_data     one byte per requester, packed
//   req_last     per requester: the offered byte ends the packet
//   req_ready    per requester: 1-cycle pop pulse, the byte was taken
//   grant        one-hot owner of the transmitter, all zero when idle
//   tx_data      byte for uart_tx, held from tx_start until the next tx_start
//   tx_start     1-cycle start pulse for uart_tx
//   tx_done      uart_tx idle level (high = idle / byte finished)
//   busy         high whenever the arbiter is not idle
//   stall_abort  1-cycle pulse when a grant is revoked by the stall timeout
//
// All outputs come straight from flops.

module uart_tx_arbiter #(
   parameter int unsigned REQ_COUNT = 2,
   parameter int unsigned TIMEOUT   = 1023
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [REQ_COUNT-1:0]   req_valid,
   input  logic [8*REQ_COUNT-1:0] req_data,
   input  logic [REQ_COUNT-1:0]   req_last,
   output logic [REQ_COUNT-1:0]   req_ready,
   output logic [REQ_COUNT-1:0]   grant,
   output logic [7:0]             tx_data,
   output logic                   tx_start,
   input  logic                   tx_done,
   output logic                   busy,
   output logic                   stall_abort
);

   localparam int unsigned IDX_W = $clog2(REQ_COUNT);
   localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      StIdle,
      StSend,
      StWaitLo,
      StWaitHi
   } state_e;

   state_e                 state_q, state_d;
   logic [IDX_W-1:0]       cur_q, cur_d;
   logic [IDX_W-1:0]       last_idx_q, last_idx_d;
   logic [TO_W-1:0]        stall_cnt_q, stall_cnt_d;
   logic                   last_q, last_d;
   logic [REQ_COUNT-1:0]   grant_q, grant_d;
   logic [REQ_COUNT-1:0]   req_ready_q, req_ready_d;
   logic [7:0]             tx_data_q, tx_data_d;
   logic                   tx_start_q, tx_start_d;
   logic                   busy_q, busy_d;
   logic                   stall_abort_q, stall_abort_d;

   // Signals of the currently granted requester.
   logic                   sel_valid;
   logic                   sel_last;
   logic [7:0]             sel_data;

   // Round-robin winner among the valid requesters.
   logic                   found;
   logic [IDX_W-1:0]       pick;
   logic [REQ_COUNT-1:0]   pick_oh;

   always_comb begin : sel_mux
      sel_valid = 1'b0;
      sel_last  = 1'b0;
      sel_data  = 8'h00;
      for (int unsigned r = 0; r < REQ_COUNT; r++) begin
         if (cur_q == IDX_W'(r)) begin
            sel_valid = req_valid[r];
            sel_last  = req_last[r];
            sel_data  = req_data[8*r +: 8];
         end
      end
   end

   // Scan last_idx+1, last_idx+2, ... wrapping, so the requester that finished most recently
   // is considered last. The modulo keeps this correct for non-power-of-two REQ_COUNT.
   always_comb begin : rr_pick
      found   = 1'b0;
      pick    = '0;
      pick_oh = '0;
      for (int unsigned k = 1; k <= REQ_COUNT; k++) begin
         for (int unsigned r = 0; r < REQ_COUNT; r++) begin
            if (!found && req_valid[r] && (((32'(last_idx_q) + k) % REQ_COUNT) == r)) begin
               found      = 1'b1;
               pick       = IDX_W'(r);
               pick_oh[r] = 1'b1;
            end
         end
      end
   end

   always_comb begin : fsm_next
      state_d       = state_q;
      cur_d         = cur_q;
      last_idx_d    = last_idx_q;
      stall_cnt_d   = stall_cnt_q;
      last_d        = last_q;
      grant_d       = grant_q;
      tx_data_d     = tx_data_q;
      req_ready_d   = '0;
      tx_start_d    = 1'b0;
      stall_abort_d = 1'b0;

      case (state_q)
         StIdle: begin
            if (found) begin
               cur_d       = pick;
               grant_d     = pick_oh;
               stall_cnt_d = '0;
               state_d     = StSend;
            end
         end

         StSend: begin
            if (sel_valid && tx_done) begin
               tx_data_d   = sel_data;
               tx_start_d  = 1'b1;
               // grant_q is already the one-hot of cur_q.
               req_ready_d = grant_q;
               last_d      = sel_last;
               stall_cnt_d = '0;
               state_d     = StWaitLo;
            end else if (!sel_valid) begin
               if (stall_cnt_q == TO_W'(TIMEOUT - 1)) begin
                  grant_d       = '0;
                  last_idx_d    = cur_q;
                  stall_abort_d = 1'b1;
                  stall_cnt_d   = '0;
                  state_d       = StIdle;
               end else begin
                  stall_cnt_d = stall_cnt_q + TO_W'(1);
               end
            end
         end

         // uart_tx drops done once it has latched the byte.
         StWaitLo: begin
            if (!tx_done) begin
               state_d = StWaitHi;
            end
         end

         StWaitHi: begin
            if (tx_done) begin
               if (last_q) begin
                  grant_d    = '0;
                  last_idx_d = cur_q;
                  state_d    = StIdle;
               end else begin
                  state_d = StSend;
               end
            end
         end

         default: begin
            grant_d = '0;
            state_d = StIdle;
         end
      endcase

      busy_d = (state_d != StIdle);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= StIdle;
         cur_q         <= '0;
         last_idx_q    <= IDX_W'(REQ_COUNT - 1);
         stall_cnt_q   <= '0;
         last_q        <= 1'b0;
         grant_q       <= '0;
         req_ready_q   <= '0;
         tx_data_q     <= 8'hFF;
         tx_start_q    <= 1'b0;
         busy_q        <= 1'b0;
         stall_abort_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         cur_q         <= cur_d;
         last_idx_q    <= last_idx_d;
         stall_cnt_q   <= stall_cnt_d;
         last_q        <= last_d;
         grant_q       <= grant_d;
         req_ready_q   <= req_ready_d;
         tx_data_q     <= tx_data_d;
         tx_start_q    <= tx_start_d;
         busy_q        <= busy_d;
         stall_abort_q <= stall_abort_d;
      end
   end

   assign req_ready   = req_ready_q;
   assign grant       = grant_q;
   assign tx_data     = tx_data_q;
   assign tx_start    = tx_start_q;
   assign busy        = busy_q;
   assign stall_abort = stall_abort_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter with three requesters and an 8-cycle stall timeout.
// Requesters are byte queues; uart_tx is a small model that drops done one cycle after it
// samples tx_start and raises it again after FRAME cycles.

module tb_uart_tx_arbiter;

   localparam int NR    = 3;
   localparam int TO    = 8;
   localparam int FRAME = 4;

   logic            clk;
   logic            rst;
   logic [NR-1:0]   req_valid;
   logic [8*NR-1:0] req_data;
   logic [NR-1:0]   req_last;
   logic [NR-1:0]   req_ready;
   logic [NR-1:0]   grant;
   logic [7:0]      tx_data;
   logic            tx_start;
   logic            tx_done;
   logic            busy;
   logic            stall_abort;

   uart_tx_arbiter #(
      .REQ_COUNT (NR),
      .TIMEOUT   (TO)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_data    (req_data),
      .req_last    (req_last),
      .req_ready   (req_ready),
      .grant       (grant),
      .tx_data     (tx_data),
      .tx_start    (tx_start),
      .tx_done     (tx_done),
      .busy        (busy),
      .stall_abort (stall_abort)
   );

   int         total = 0;
   int         bad   = 0;

   // Pending bytes per requester.
   logic [7:0] q_data [NR][$];
   logic       q_last [NR][$];

   // Expected serial stream (owner, byte) and the observed one.
   int         exp_r [$];
   logic [7:0] exp_b [$];
   int         log_r [$];
   logic [7:0] log_b [$];

   // Model's notion of the requester that finished most recently.
   int         mdl_last = NR - 1;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, want, $time);
      end
   endtask

   function automatic int oh2idx(input logic [NR-1:0] v);
      for (int i = 0; i < NR; i++) begin
         if (v[i]) return i;
      end
      return -1;
   endfunction

   function automatic bit queues_empty();
      for (int r = 0; r < NR; r++) begin
         if (q_data[r].size() != 0) return 1'b0;
      end
      return 1'b1;
   endfunction

   task automatic push(input int r, input logic [7:0] b, input logic last);
      q_data[r].push_back(b);
      q_last[r].push_back(last);
   endtask

   // Expected order when everything queued is visible at once and the arbiter is idle:
   // whole packets, next requester strictly after the previous winner, wrapping.
   task automatic model_plan();
      int pos [NR];
      int pk;
      int c;
      for (int r = 0; r < NR; r++) pos[r] = 0;
      for (int n = 0; n < 64; n++) begin
         pk = -1;
         for (int k = 1; k <= NR; k++) begin
            c = (mdl_last + k) % NR;
            if (pk < 0 && pos[c] < q_data[c].size()) pk = c;
         end
         if (pk < 0) break;
         while (pos[pk] < q_data[pk].size()) begin
            exp_r.push_back(pk);
            exp_b.push_back(q_data[pk][pos[pk]]);
            pos[pk]++;
            if (q_last[pk][pos[pk] - 1]) break;
         end
         mdl_last = pk;
      end
   endtask

   // which: 0 = tx_start, 1 = tx_done, 2 = stall_abort
   task automatic wait_until(input int which, input logic lvl, input int budget,
                             input string name);
      logic s;
      s = ~lvl;
      for (int i = 0; i < budget && s !== lvl; i++) begin
         @(negedge clk);
         s = (which == 0) ? tx_start : (which == 1) ? tx_done : stall_abort;
      end
      if (s !== lvl) check(name, 32'(s), 32'(lvl));
   endtask

   task automatic wait_idle(input int budget);
      int quiet;
      quiet = 0;
      for (int i = 0; i < budget && quiet < 3; i++) begin
         @(negedge clk);
         if (!busy && tx_done && queues_empty() && exp_r.size() == 0) quiet++;
         else quiet = 0;
      end
      if (quiet < 3) check("idle_timeout", 32'(quiet), 32'd3);
   endtask

   // Requester and uart_tx models, updated just after each rising edge.
   initial begin
      int         frame_cnt;
      logic       start_d;
      logic [7:0] tmp_b;
      logic       tmp_l;
      frame_cnt = 0;
      start_d   = 1'b0;
      tx_done   = 1'b1;
      req_valid = '0;
      req_data  = '0;
      req_last  = '0;
      forever begin
         @(posedge clk);
         #1;
         if (start_d) frame_cnt = FRAME;
         else if (frame_cnt > 0) frame_cnt--;
         start_d = (tx_start === 1'b1);
         tx_done = (frame_cnt == 0);
         for (int r = 0; r < NR; r++) begin
            if (req_ready[r] === 1'b1 && q_data[r].size() != 0) begin
               tmp_b = q_data[r].pop_front();
               tmp_l = q_last[r].pop_front();
            end
            if (q_data[r].size() != 0) begin
               req_valid[r]       = 1'b1;
               req_data[8*r +: 8] = q_data[r][0];
               req_last[r]        = q_last[r][0];
            end else begin
               req_valid[r]       = 1'b0;
               req_data[8*r +: 8] = 8'h00;
               req_last[r]        = 1'b0;
            end
         end
      end
   end

   // Per-cycle comparison against the expected stream and the output rules.
   initial begin
      logic [7:0] prev_data;
      logic       prev_ok;
      int         er;
      logic [7:0] eb;
      prev_ok   = 1'b0;
      prev_data = 8'h00;
      forever begin
         @(negedge clk);
         if (!rst) begin
            check("busy_vs_grant", 32'(busy), 32'(grant != '0));
            check("grant_onehot0", 32'($onehot0(grant)), 32'd1);
            check("ready_vs_start", 32'(req_ready), tx_start ? 32'(grant) : 32'd0);
            if (tx_start) begin
               log_r.push_back(oh2idx(grant));
               log_b.push_back(tx_data);
               check("start_expected", 32'(exp_r.size() != 0), 32'd1);
               if (exp_r.size() != 0) begin
                  er = exp_r.pop_front();
                  eb = exp_b.pop_front();
                  check("start_owner", oh2idx(grant), er);
                  check("start_data", 32'(tx_data), 32'(eb));
               end
            end else if (prev_ok) begin
               check("tx_data_hold", 32'(tx_data), 32'(prev_data));
            end
            if (stall_abort) check("abort_grant", 32'(grant), 32'd0);
         end
         prev_ok   = !rst;
         prev_data = tx_data;
      end
   end

   initial begin
      int         k;
      int         w_r [6];
      logic [7:0] w_b [6];

      // Reset with nothing requested.
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_tx_data", 32'(tx_data), 32'hFF);
      check("rst_grant", 32'(grant), 32'd0);
      check("rst_ready", 32'(req_ready), 32'd0);
      check("rst_abort", 32'(stall_abort), 32'd0);
      rst = 1'b0;
      repeat (6) begin
         @(negedge clk);
         check("idle_grant", 32'(grant), 32'd0);
         check("idle_busy", 32'(busy), 32'd0);
         check("idle_start", 32'(tx_start), 32'd0);
         check("idle_tx_data", 32'(tx_data), 32'hFF);
      end

      // Single one-byte packet from r0.
      push(0, 8'h41, 1'b1);
      model_plan();
      @(negedge clk);
      check("t2_grant_not_yet", 32'(grant), 32'd0);
      @(negedge clk);
      check("t2_grant", 32'(grant), 32'b001);
      check("t2_busy", 32'(busy), 32'd1);
      @(negedge clk);
      check("t2_start", 32'(tx_start), 32'd1);
      check("t2_data", 32'(tx_data), 32'h41);
      check("t2_ready", 32'(req_ready), 32'b001);
      @(negedge clk);
      check("t2_start_pulse", 32'(tx_start), 32'd0);
      check("t2_ready_pulse", 32'(req_ready), 32'd0);
      wait_idle(80);
      check("t2_released", 32'(grant), 32'd0);

      // Atomic 3-byte packet from r1 with r0 waiting throughout.
      log_r.delete();
      log_b.delete();
      push(1, 8'h10, 1'b0);
      push(1, 8'h11, 1'b0);
      push(1, 8'h12, 1'b1);
      push(0, 8'h50, 1'b1);
      model_plan();
      wait_idle(300);
      w_r[0:3] = '{1, 1, 1, 0};
      w_b[0:3] = '{8'h10, 8'h11, 8'h12, 8'h50};
      check("t3_count", 32'(log_r.size()), 32'd4);
      for (int i = 0; i < 4 && i < log_r.size(); i++) begin
         check("t3_owner", log_r[i], w_r[i]);
         check("t3_byte", 32'(log_b[i]), 32'(w_b[i]));
      end

      // Round-robin from reset with every requester holding two one-byte packets.
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      mdl_last = NR - 1;
      log_r.delete();
      log_b.delete();
      for (int r = 0; r < NR; r++) begin
         push(r, 8'h60 + 8'(16 * r), 1'b1);
         push(r, 8'h61 + 8'(16 * r), 1'b1);
      end
      model_plan();
      wait_idle(400);
      w_r = '{0, 1, 2, 0, 1, 2};
      w_b = '{8'h60, 8'h70, 8'h80, 8'h61, 8'h71, 8'h81};
      check("t4_count", 32'(log_r.size()), 32'd6);
      for (int i = 0; i < 6 && i < log_r.size(); i++) begin
         check("t4_owner", log_r[i], w_r[i]);
         check("t4_byte", 32'(log_b[i]), 32'(w_b[i]));
      end

      // Stall timeout: r0 sends one non-last byte and goes quiet, r1 is pending.
      log_r.delete();
      log_b.delete();
      push(0, 8'hAA, 1'b0);
      push(1, 8'hB1, 1'b1);
      exp_r.push_back(0);
      exp_b.push_back(8'hAA);
      exp_r.push_back(1);
      exp_b.push_back(8'hB1);
      mdl_last = 1;
      wait_until(0, 1'b1, 30, "t5_start_timeout");
      wait_until(1, 1'b0, 30, "t5_done_lo_timeout");
      wait_until(1, 1'b1, 30, "t5_done_hi_timeout");
      // Eight stalled cycles in SEND, then the registered pulse.
      k = 0;
      for (int i = 0; i < 30 && stall_abort !== 1'b1; i++) begin
         @(negedge clk);
         k++;
      end
      check("t5_abort_delay", 32'(k), 32'd9);
      check("t5_abort_grant", 32'(grant), 32'd0);
      check("t5_abort_busy", 32'(busy), 32'd0);
      @(negedge clk);
      check("t5_abort_pulse", 32'(stall_abort), 32'd0);
      check("t5_next_grant", 32'(grant), 32'b010);
      wait_idle(100);

      // Reset during WAIT_HI of a 2-byte packet.
      push(0, 8'hC1, 1'b0);
      push(0, 8'hC2, 1'b1);
      exp_r.push_back(0);
      exp_b.push_back(8'hC1);
      wait_until(0, 1'b1, 30, "t6_start_timeout");
      wait_until(1, 1'b0, 30, "t6_done_lo_timeout");
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("t6_grant", 32'(grant), 32'd0);
      check("t6_busy", 32'(busy), 32'd0);
      check("t6_start", 32'(tx_start), 32'd0);
      check("t6_ready", 32'(req_ready), 32'd0);
      check("t6_abort", 32'(stall_abort), 32'd0);
      check("t6_tx_data", 32'(tx_data), 32'hFF);
      check("t6_not_popped", 32'(q_data[0].size()), 32'd1);
      check("t6_first_sent", 32'(exp_r.size()), 32'd0);
      q_data[0].delete();
      q_last[0].delete();
      exp_r.delete();
      exp_b.delete();
      @(negedge clk);
      rst = 1'b0;
      mdl_last = NR - 1;
      wait_idle(60);
      check("t6_idle_grant", 32'(grant), 32'd0);

      check("exp_left", 32'(exp_r.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
